// File: rtl/button_pulse_conditioner.sv
// Synchronises, debounces and edge-conditions the up/down select buttons.
// Emits one-cycle press and auto-repeat pulses; pressing both buttons together blocks all pulses.
module button_pulse_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic upButtonRaw,
    input  logic downButtonRaw,
    output logic upPulse,
    output logic downPulse,
    output logic upLevel,
    output logic downLevel
);

    localparam int DW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] RD_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RP_LAST  = RW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        REPEAT
    } state_t;

    logic [1:0] raw;
    logic [1:0] sync1;
    logic [1:0] sync2;
    logic [1:0] level;
    logic [1:0] level_nx;
    logic [1:0] pulse_q;
    logic       both_now;
    logic       both_nx;

    // After polarity correction, 1 always means pressed.
    assign raw = {downButtonRaw, upButtonRaw} ^ {2{ACTIVE_LOW}};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    assign both_now = level[0] & level[1];
    assign both_nx  = level_nx[0] & level_nx[1];

    for (genvar b = 0; b < 2; b++) begin : g_btn
        logic          lvl;
        logic          lvl_d;
        logic          lvl_nx;
        logic [DW-1:0] dcnt;
        logic [DW-1:0] dcnt_nx;
        state_t        state;
        state_t        state_nx;
        logic [RW-1:0] rcnt;
        logic [RW-1:0] rcnt_nx;
        logic          fire;

        always_comb begin
            lvl_nx  = lvl;
            dcnt_nx = '0;
            if (sync2[b] != lvl) begin
                if (dcnt == DB_LAST) begin
                    lvl_nx = sync2[b];
                end else begin
                    dcnt_nx = dcnt + 1'b1;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                lvl   <= 1'b0;
                lvl_d <= 1'b0;
                dcnt  <= '0;
            end else begin
                lvl   <= lvl_nx;
                lvl_d <= lvl;
                dcnt  <= dcnt_nx;
            end
        end

        assign level[b]    = lvl;
        assign level_nx[b] = lvl_nx;

        always_ff @(posedge clk) begin
            if (rst) begin
                state      <= IDLE;
                rcnt       <= '0;
                pulse_q[b] <= 1'b0;
            end else begin
                state      <= state_nx;
                rcnt       <= rcnt_nx;
                // Gate on next levels so no pulse lands in a both-pressed cycle.
                pulse_q[b] <= fire & ~both_nx;
            end
        end

        always_comb begin
            state_nx = state;
            rcnt_nx  = '0;
            unique case (state)
                IDLE: begin
                    if (lvl && !lvl_d && !both_now) begin
                        state_nx = HOLD;
                    end
                end
                HOLD: begin
                    if (!lvl || both_now) begin
                        state_nx = IDLE;
                    end else if (rcnt == RD_LAST) begin
                        state_nx = REPEAT;
                    end else begin
                        rcnt_nx = rcnt + 1'b1;
                    end
                end
                REPEAT: begin
                    if (!lvl || both_now) begin
                        state_nx = IDLE;
                    end else if (rcnt != RP_LAST) begin
                        rcnt_nx = rcnt + 1'b1;
                    end
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end

        always_comb begin
            fire = 1'b0;
            unique case (state)
                IDLE:    fire = lvl && !lvl_d && !both_now;
                HOLD:    fire = lvl && !both_now && (rcnt == RD_LAST);
                REPEAT:  fire = lvl && !both_now && (rcnt == RP_LAST);
                default: fire = 1'b0;
            endcase
        end
    end

    assign upPulse   = pulse_q[0];
    assign downPulse = pulse_q[1];
    assign upLevel   = level[0];
    assign downLevel = level[1];

endmodule

// File: tb/tb_button_pulse_conditioner.sv
// Random and directed stimulus for button_pulse_conditioner.
// Outputs are compared every cycle against a window/schedule reference model.
module tb_button_pulse_conditioner;

    localparam int D    = 4;
    localparam int RD   = 20;
    localparam int RP   = 8;
    localparam int MAXC = 4000;

    logic clk = 1'b0;
    logic rst;
    logic upButtonRaw;
    logic downButtonRaw;
    logic upPulse;
    logic downPulse;
    logic upLevel;
    logic downLevel;

    button_pulse_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .ACTIVE_LOW     (1'b1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .upButtonRaw  (upButtonRaw),
        .downButtonRaw(downButtonRaw),
        .upPulse      (upPulse),
        .downPulse    (downPulse),
        .upLevel      (upLevel),
        .downLevel    (downLevel)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state: h = pressed sample per edge, lv = debounced level after each edge.
    bit h  [2][0:MAXC-1];
    bit lv [2][0:MAXC-1];
    bit armed [2];
    int start [2];
    bit mp    [2];
    int n;

    int obs_up;
    int obs_dn;
    int first_up;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s at edge %0d: got=%0d exp=%0d", tag, n, got, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit pu, input bit pd);
        bit fire [2];
        if (r) begin
            for (int b = 0; b < 2; b++) begin
                h[b][n]     = 1'b0;
                h[b][n-1]   = 1'b0;
                lv[b][n]    = 1'b0;
                armed[b]    = 1'b0;
                mp[b]       = 1'b0;
            end
            return;
        end
        h[0][n] = pu;
        h[1][n] = pd;
        // Level flips once the last D synchronised samples all disagree with it.
        for (int b = 0; b < 2; b++) begin
            bit stable;
            stable = 1'b1;
            for (int k = 0; k < D; k++)
                if (h[b][n-2-k] == lv[b][n-1]) stable = 1'b0;
            lv[b][n] = stable ? ~lv[b][n-1] : lv[b][n-1];
        end
        for (int b = 0; b < 2; b++) begin
            bit pre, prv, oth;
            int age;
            pre = lv[b][n-1];
            prv = lv[b][n-2];
            oth = lv[1-b][n-1];
            if (pre && oth) armed[b] = 1'b0;
            else if (!pre) armed[b] = 1'b0;
            else if (!prv) begin
                armed[b] = 1'b1;
                start[b] = n;
            end
            age = n - start[b];
            fire[b] = armed[b] &&
                      (age == 0 || (age >= RD && (age - RD) % RP == 0));
        end
        for (int b = 0; b < 2; b++)
            mp[b] = fire[b] && !(lv[0][n] && lv[1][n]);
    endtask

    task automatic step(input bit r, input bit pu, input bit pd);
        rst           = r;
        upButtonRaw   = ~pu;
        downButtonRaw = ~pd;
        @(posedge clk);
        n++;
        model_edge(r, pu, pd);
        @(negedge clk);
        check("upLevel",   int'(upLevel),   int'(lv[0][n]));
        check("downLevel", int'(downLevel), int'(lv[1][n]));
        check("upPulse",   int'(upPulse),   int'(mp[0]));
        check("downPulse", int'(downPulse), int'(mp[1]));
        if (upPulse) begin
            obs_up++;
            if (first_up < 0) first_up = n;
        end
        if (downPulse) obs_dn++;
    endtask

    task automatic run(input int cyc, input bit r, input bit pu, input bit pd);
        for (int i = 0; i < cyc; i++) step(r, pu, pd);
    endtask

    initial begin
        int rst_edge;
        n        = D + 2;
        obs_up   = 0;
        obs_dn   = 0;
        first_up = -1;
        rst           = 1'b1;
        upButtonRaw   = 1'b1;
        downButtonRaw = 1'b1;
        @(negedge clk);

        run(3, 1'b1, 1'b0, 1'b0);
        obs_up = 0; obs_dn = 0;
        run(50, 1'b0, 1'b0, 1'b0);
        check("idle_up_pulses", obs_up, 0);
        check("idle_dn_pulses", obs_dn, 0);

        obs_up = 0; obs_dn = 0;
        run(10, 1'b0, 1'b1, 1'b0);
        run(30, 1'b0, 1'b0, 1'b0);
        check("clean_up_pulses", obs_up, 1);
        check("clean_dn_pulses", obs_dn, 0);

        obs_up = 0;
        for (int i = 0; i < 10; i++) run(2, 1'b0, (i % 2) == 0, 1'b0);
        run(10, 1'b0, 1'b0, 1'b0);
        run(3, 1'b0, 1'b1, 1'b0);
        run(15, 1'b0, 1'b0, 1'b0);
        check("bounce_up_pulses", obs_up, 0);

        run(60, 1'b0, 1'b0, 1'b1);
        run(30, 1'b0, 1'b0, 1'b0);

        run(12, 1'b0, 1'b1, 1'b0);
        obs_up = 0; obs_dn = 0;
        run(40, 1'b0, 1'b1, 1'b1);
        check("both_dn_pulses", obs_dn, 0);
        check("both_up_pulses", obs_up, 0);
        obs_up = 0;
        run(40, 1'b0, 1'b1, 1'b0);
        check("leftover_up_pulses", obs_up, 0);
        run(10, 1'b0, 1'b0, 1'b0);
        obs_up = 0;
        run(12, 1'b0, 1'b1, 1'b0);
        run(10, 1'b0, 1'b0, 1'b0);
        check("repress_up_pulses", obs_up, 1);

        run(40, 1'b0, 1'b1, 1'b0);
        run(1, 1'b1, 1'b1, 1'b0);
        rst_edge = n;
        check("rst_mid_upLevel", int'(upLevel), 0);
        first_up = -1;
        run(20, 1'b0, 1'b1, 1'b0);
        check("rst_repulse_delay", first_up - rst_edge, D + 3);
        run(10, 1'b0, 1'b0, 1'b0);

        while (n < MAXC - 60) begin
            bit rr;
            rr = ($urandom_range(0, 39) == 0);
            run(rr ? 1 : int'($urandom_range(1, 30)), rr,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
